// File: rtl/fir_pkg.sv
// fir_pkg: shared widths and types for the FIR accumulate/count datapath.
//   FIR_ACC_W  - accumulator width, Q6.15 (5 guard bits over Q1.15)
//   FIR_ADDR_W - sample RAM address width
//   FIR_CNT_W  - programmed sample count width
package fir_pkg;

  localparam int FIR_ACC_W  = 21;
  localparam int FIR_ADDR_W = 13;
  localparam int FIR_CNT_W  = 14;

  typedef logic signed [FIR_ACC_W-1:0] acc_t;
  typedef logic [FIR_ADDR_W-1:0]       addr_t;

endpackage

// File: rtl/fir_sum_add.sv
// fir_sum_add: combinational sign-extend of a Q1.15 product term and add to
// the running Q6.15 sum.
// Optional build macro: FIR_ACC_SAT_EN - clamp to max/min signed on overflow
// instead of wrapping modulo 2^WIDTH.
// Ports:
//   acc  in  WIDTH  current accumulator value
//   term in  16     product term, signed Q1.15
//   sum  out WIDTH  acc + sign-extended term
module fir_sum_add import fir_pkg::*; #(
  parameter int WIDTH = FIR_ACC_W
) (
  input  logic [WIDTH-1:0] acc,
  input  logic [15:0]      term,
  output logic [WIDTH-1:0] sum
);

  logic [WIDTH-1:0] term_ext;
  logic [WIDTH-1:0] raw;

  assign term_ext = {{(WIDTH-16){term[15]}}, term};
  assign raw      = acc + term_ext;

`ifdef FIR_ACC_SAT_EN
  logic ovf;

  // Overflow only possible when both operands share a sign and the result flips it.
  assign ovf = (acc[WIDTH-1] == term_ext[WIDTH-1]) && (raw[WIDTH-1] != acc[WIDTH-1]);

  always_comb begin
    sum = raw;
    if (ovf) begin
      sum = acc[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign sum = raw;
`endif

endmodule

// File: rtl/fir_acc_datapath.sv
// fir_acc_datapath: accumulate-and-count datapath of the FIR engine.
// Optional build macro: FIR_ACC_SAT_EN (saturating adder, see fir_sum_add).
// Ports:
//   clk_b, rst            clock, async active-high reset
//   mnozenie_wynik        product term, Q1.15
//   FSM_Acc_en            load accumulator with suma_wynik
//   FSM_Acc_zapis         capture Acc_out into FIR_probka_wynik
//   FSM_reset_Acc         synchronous accumulator clear (wins over FSM_Acc_en)
//   suma_wynik            combinational running sum
//   Acc_out               accumulator register
//   FIR_probka_wynik      captured sample result
//   ile_probek            number of samples to process
//   FSM_zapisz_probki     latch ile_probek and clear the address
//   FSM_reset_licznik     clear the address
//   FSM_nowa_probka       advance the address
//   A_probki_FIR          current sample address
//   licznik_full          current address is the last sample
module fir_acc_datapath import fir_pkg::*; #(
  parameter int WIDTH      = FIR_ACC_W,
  parameter int ADDR_WIDTH = FIR_ADDR_W,
  parameter int CNT_WIDTH  = FIR_CNT_W
) (
  input  logic                  clk_b,
  input  logic                  rst,
  input  logic [15:0]           mnozenie_wynik,
  input  logic                  FSM_Acc_en,
  input  logic                  FSM_Acc_zapis,
  input  logic                  FSM_reset_Acc,
  output logic [WIDTH-1:0]      suma_wynik,
  output logic [WIDTH-1:0]      Acc_out,
  output logic [WIDTH-1:0]      FIR_probka_wynik,
  input  logic [CNT_WIDTH-1:0]  ile_probek,
  input  logic                  FSM_zapisz_probki,
  input  logic                  FSM_reset_licznik,
  input  logic                  FSM_nowa_probka,
  output logic [ADDR_WIDTH-1:0] A_probki_FIR,
  output logic                  licznik_full
);

  logic [CNT_WIDTH-1:0] n_cnt;
  logic [CNT_WIDTH-1:0] n_last;

  fir_sum_add #(.WIDTH(WIDTH)) u_sum (
    .acc  (Acc_out),
    .term (mnozenie_wynik),
    .sum  (suma_wynik)
  );

  always_ff @(posedge clk_b or posedge rst) begin
    if (rst) begin
      Acc_out <= '0;
    end else if (FSM_reset_Acc) begin
      Acc_out <= '0;
    end else if (FSM_Acc_en) begin
      Acc_out <= suma_wynik;
    end
  end

  // Capture sees the pre-edge accumulator regardless of clear/load on the same edge.
  always_ff @(posedge clk_b or posedge rst) begin
    if (rst) begin
      FIR_probka_wynik <= '0;
    end else if (FSM_Acc_zapis) begin
      FIR_probka_wynik <= Acc_out;
    end
  end

  assign n_last       = n_cnt - CNT_WIDTH'(1);
  // A zero count has no valid sample, so it reads as already full.
  assign licznik_full = (n_cnt == '0) || (CNT_WIDTH'(A_probki_FIR) == n_last);

  // The all-ones guard keeps the address from wrapping when the count exceeds the RAM.
  always_ff @(posedge clk_b or posedge rst) begin
    if (rst) begin
      n_cnt        <= '0;
      A_probki_FIR <= '0;
    end else if (FSM_zapisz_probki) begin
      n_cnt        <= ile_probek;
      A_probki_FIR <= '0;
    end else if (FSM_reset_licznik) begin
      A_probki_FIR <= '0;
    end else if (FSM_nowa_probka && !licznik_full && (A_probki_FIR != '1)) begin
      A_probki_FIR <= A_probki_FIR + ADDR_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_fir_acc_datapath.sv
module tb_fir_acc_datapath;
  import fir_pkg::*;

  logic        clk_b = 1'b0;
  logic        rst;
  logic [15:0] mnozenie_wynik;
  logic        FSM_Acc_en, FSM_Acc_zapis, FSM_reset_Acc;
  logic [20:0] suma_wynik, Acc_out, FIR_probka_wynik;
  logic [13:0] ile_probek;
  logic        FSM_zapisz_probki, FSM_reset_licznik, FSM_nowa_probka;
  logic [12:0] A_probki_FIR;
  logic        licznik_full;

  int checks = 0;
  int errors = 0;

  // Behavioural model: signed integers and plain counters.
  int m_acc, m_res, m_n, m_addr, m_sum;
  logic [20:0] sum_pre;

  always #5 clk_b = ~clk_b;

  fir_acc_datapath dut (
    .clk_b             (clk_b),
    .rst               (rst),
    .mnozenie_wynik    (mnozenie_wynik),
    .FSM_Acc_en        (FSM_Acc_en),
    .FSM_Acc_zapis     (FSM_Acc_zapis),
    .FSM_reset_Acc     (FSM_reset_Acc),
    .suma_wynik        (suma_wynik),
    .Acc_out           (Acc_out),
    .FIR_probka_wynik  (FIR_probka_wynik),
    .ile_probek        (ile_probek),
    .FSM_zapisz_probki (FSM_zapisz_probki),
    .FSM_reset_licznik (FSM_reset_licznik),
    .FSM_nowa_probka   (FSM_nowa_probka),
    .A_probki_FIR      (A_probki_FIR),
    .licznik_full      (licznik_full)
  );

  typedef struct {
    logic [15:0] t;
    logic        en, zap, racc;
    logic [13:0] ile;
    logic        zpr, rlic, nowa;
    logic [20:0] e_sum, e_acc, e_res;
    logic [12:0] e_addr;
    logic        e_full;
  } vec_t;

  vec_t tbl[19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_add(input int a, input logic [15:0] t);
    int s;
    s = a + int'($signed(t));
`ifdef FIR_ACC_SAT_EN
    if (s > 1048575) s = 1048575;
    if (s < -1048576) s = -1048576;
`else
    if (s > 1048575) s -= 2097152;
    else if (s < -1048576) s += 2097152;
`endif
    return s;
  endfunction

  function automatic logic [31:0] bits21(input int v);
    return 32'(v) & 32'h1FFFFF;
  endfunction

  // Drive one cycle of strobes: sample the sum before the edge, advance the model at the edge.
  task automatic step(input logic [15:0] t, input logic en, input logic zap, input logic racc,
                      input logic [13:0] ile, input logic zpr, input logic rlic, input logic nowa);
    bit full;
    mnozenie_wynik    = t;
    FSM_Acc_en        = en;
    FSM_Acc_zapis     = zap;
    FSM_reset_Acc     = racc;
    ile_probek        = ile;
    FSM_zapisz_probki = zpr;
    FSM_reset_licznik = rlic;
    FSM_nowa_probka   = nowa;
    #1;
    sum_pre = suma_wynik;
    m_sum   = m_add(m_acc, t);
    @(posedge clk_b);
    full = (m_n == 0) || (m_addr == m_n - 1);
    if (zap) m_res = m_acc;
    if (racc) m_acc = 0;
    else if (en) m_acc = m_sum;
    if (zpr) begin
      m_n    = int'(ile);
      m_addr = 0;
    end else if (rlic) begin
      m_addr = 0;
    end else if (nowa && !full && m_addr < 8191) begin
      m_addr++;
    end
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".sum"},  32'(sum_pre), bits21(m_sum));
    chk({tag, ".acc"},  32'(Acc_out), bits21(m_acc));
    chk({tag, ".res"},  32'(FIR_probka_wynik), bits21(m_res));
    chk({tag, ".addr"}, 32'(A_probki_FIR), 32'(m_addr));
    chk({tag, ".full"}, 32'(licznik_full), 32'((m_n == 0) || (m_addr == m_n - 1)));
  endtask

  initial begin
    rst = 1'b1;
    mnozenie_wynik = '0; FSM_Acc_en = 0; FSM_Acc_zapis = 0; FSM_reset_Acc = 0;
    ile_probek = '0; FSM_zapisz_probki = 0; FSM_reset_licznik = 0; FSM_nowa_probka = 0;
    m_acc = 0; m_res = 0; m_n = 0; m_addr = 0; m_sum = 0;

    //            t        en zap racc ile zpr rlic nowa  sum        acc        res        addr full
    tbl[0]  = '{16'h1000, 1, 0, 0, 0, 0, 0, 0, 21'h001000, 21'h001000, 21'h0,      0, 1};
    tbl[1]  = '{16'h1000, 1, 0, 0, 0, 0, 0, 0, 21'h002000, 21'h002000, 21'h0,      0, 1};
    tbl[2]  = '{16'h1000, 1, 0, 0, 0, 0, 0, 0, 21'h003000, 21'h003000, 21'h0,      0, 1};
    tbl[3]  = '{16'h1000, 1, 1, 0, 0, 0, 0, 0, 21'h004000, 21'h004000, 21'h003000, 0, 1};
    tbl[4]  = '{16'h0000, 0, 1, 1, 0, 0, 0, 0, 21'h004000, 21'h000000, 21'h004000, 0, 1};
    tbl[5]  = '{16'hC000, 0, 0, 0, 0, 0, 0, 0, 21'h1FC000, 21'h000000, 21'h004000, 0, 1};
    tbl[6]  = '{16'hC000, 1, 0, 0, 0, 0, 0, 0, 21'h1FC000, 21'h1FC000, 21'h004000, 0, 1};
    tbl[7]  = '{16'h4000, 1, 0, 0, 0, 0, 0, 0, 21'h000000, 21'h000000, 21'h004000, 0, 1};
    tbl[8]  = '{16'h1000, 1, 0, 1, 0, 0, 0, 0, 21'h001000, 21'h000000, 21'h004000, 0, 1};
    tbl[9]  = '{16'h0000, 0, 0, 0, 3, 1, 0, 0, 21'h000000, 21'h000000, 21'h004000, 0, 0};
    tbl[10] = '{16'h0000, 0, 0, 0, 0, 0, 0, 1, 21'h000000, 21'h000000, 21'h004000, 1, 0};
    tbl[11] = '{16'h0000, 0, 0, 0, 0, 0, 0, 1, 21'h000000, 21'h000000, 21'h004000, 2, 1};
    tbl[12] = '{16'h0000, 0, 0, 0, 0, 0, 0, 1, 21'h000000, 21'h000000, 21'h004000, 2, 1};
    tbl[13] = '{16'h0000, 0, 0, 0, 0, 0, 1, 0, 21'h000000, 21'h000000, 21'h004000, 0, 0};
    tbl[14] = '{16'h0000, 0, 0, 0, 0, 1, 0, 0, 21'h000000, 21'h000000, 21'h004000, 0, 1};
    tbl[15] = '{16'h0000, 0, 0, 0, 0, 0, 0, 1, 21'h000000, 21'h000000, 21'h004000, 0, 1};
    tbl[16] = '{16'h0000, 0, 0, 0, 5, 1, 1, 1, 21'h000000, 21'h000000, 21'h004000, 0, 0};
    tbl[17] = '{16'h0000, 0, 0, 0, 0, 0, 1, 1, 21'h000000, 21'h000000, 21'h004000, 0, 0};
    tbl[18] = '{16'h0000, 0, 0, 0, 0, 0, 0, 1, 21'h000000, 21'h000000, 21'h004000, 1, 0};

    #2;
    chk("rst.acc",  32'(Acc_out), 0);
    chk("rst.res",  32'(FIR_probka_wynik), 0);
    chk("rst.addr", 32'(A_probki_FIR), 0);
    chk("rst.full", 32'(licznik_full), 1);
    #10 rst = 1'b0;
    @(posedge clk_b); #1;

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].t, tbl[i].en, tbl[i].zap, tbl[i].racc, tbl[i].ile,
           tbl[i].zpr, tbl[i].rlic, tbl[i].nowa);
      chk($sformatf("tbl%0d.sum", i),  32'(sum_pre), 32'(tbl[i].e_sum));
      chk($sformatf("tbl%0d.acc", i),  32'(Acc_out), 32'(tbl[i].e_acc));
      chk($sformatf("tbl%0d.res", i),  32'(FIR_probka_wynik), 32'(tbl[i].e_res));
      chk($sformatf("tbl%0d.addr", i), 32'(A_probki_FIR), 32'(tbl[i].e_addr));
      chk($sformatf("tbl%0d.full", i), 32'(licznik_full), 32'(tbl[i].e_full));
    end

    // Positive overflow: 32 x 0x7F80 builds 0x0FF000, then add 0x7FFF.
    step(16'h0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) step(16'h7F80, 1, 0, 0, 0, 0, 0, 0);
    chk("satp.base", 32'(Acc_out), 32'h0FF000);
    step(16'h7FFF, 1, 0, 0, 0, 0, 0, 0);
`ifdef FIR_ACC_SAT_EN
    chk("satp.sum", 32'(sum_pre), 32'h0FFFFF);
`else
    chk("satp.sum", 32'(sum_pre), 32'h106FFF);
`endif
    chk_model("satp");

    // Negative overflow: 32 x 0x8080 builds 0x101000, then add 0x8000.
    step(16'h0, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) step(16'h8080, 1, 0, 0, 0, 0, 0, 0);
    chk("satn.base", 32'(Acc_out), 32'h101000);
    step(16'h8000, 1, 0, 0, 0, 0, 0, 0);
`ifdef FIR_ACC_SAT_EN
    chk("satn.sum", 32'(sum_pre), 32'h100000);
`else
    chk("satn.sum", 32'(sum_pre), 32'h0F9000);
`endif
    chk_model("satn");

    // Count equal to the RAM depth: full at the last address, then held.
    step(16'h0, 0, 0, 0, 14'd8192, 1, 0, 0);
    for (int i = 0; i < 8191; i++) step(16'h0, 0, 0, 0, 0, 0, 0, 1);
    chk("n8192.addr", 32'(A_probki_FIR), 32'h1FFF);
    chk("n8192.full", 32'(licznik_full), 1);
    step(16'h0, 0, 0, 0, 0, 0, 0, 1);
    chk("n8192.hold", 32'(A_probki_FIR), 32'h1FFF);

    // Oversized count: address sticks at all-ones, full never rises.
    step(16'h0, 0, 0, 0, 14'd8193, 1, 0, 0);
    for (int i = 0; i < 8195; i++) step(16'h0, 0, 0, 0, 0, 0, 0, 1);
    chk("n8193.addr", 32'(A_probki_FIR), 32'h1FFF);
    chk("n8193.full", 32'(licznik_full), 0);

    // Asynchronous reset mid-run, between edges.
    step(16'h0, 0, 0, 1, 14'd5, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(16'h1000, 1, 0, 0, 0, 0, 0, 0);
    step(16'h0, 0, 1, 0, 0, 0, 0, 1);
    step(16'h0, 0, 0, 0, 0, 0, 0, 1);
    chk("pre_rst.acc",  32'(Acc_out), 32'h3000);
    chk("pre_rst.addr", 32'(A_probki_FIR), 2);
    FSM_nowa_probka = 0; FSM_Acc_zapis = 0;
    rst = 1'b1;
    #2;
    chk("mid_rst.acc",  32'(Acc_out), 0);
    chk("mid_rst.res",  32'(FIR_probka_wynik), 0);
    chk("mid_rst.addr", 32'(A_probki_FIR), 0);
    chk("mid_rst.full", 32'(licznik_full), 1);
    #1 rst = 1'b0;
    m_acc = 0; m_res = 0; m_n = 0; m_addr = 0;
    @(posedge clk_b); #1;

    // Randomized strobes against the model.
    for (int i = 0; i < 400; i++) begin
      logic [15:0] t;
      logic [13:0] ile;
      t   = 16'($urandom);
      ile = ($urandom_range(0, 15) == 0) ? 14'($urandom) : 14'($urandom_range(0, 6));
      step(t, ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 15) == 0), ile, ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 1) == 1));
      chk_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_acc_datapath.md
Name: fir_acc_datapath

Overview:
- Accumulate-and-count datapath of the FIR engine, driven cycle by cycle by the FIR FSM.
- Contains three parts:
  - a sign-extending adder that adds one Q1.15 multiplier term to the running sum;
  - an accumulator register with a result-capture register;
  - the sample-address counter with a "last sample" flag.
- Sits between the multiplier/coefficient RAM and the FSM/output write path.

Parameters:
- WIDTH, 21: accumulator, sum and result width (Q6.15, 5 guard bits).
- ADDR_WIDTH, 13: sample RAM address width.
- CNT_WIDTH, 14: width of the programmed sample count.

Ports:
- clk_b  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mnozenie_wynik  in  16  product term, signed Q1.15 (product bits [30:15]).
- FSM_Acc_en  in  1  load the accumulator with suma_wynik.
- FSM_Acc_zapis  in  1  capture Acc_out into FIR_probka_wynik.
- FSM_reset_Acc  in  1  synchronous clear of the accumulator.
- suma_wynik  out  WIDTH  combinational sum (Acc_out + sign-extended term).
- Acc_out  out  WIDTH  accumulator register.
- FIR_probka_wynik  out  WIDTH  captured sample result.
- ile_probek  in  CNT_WIDTH  number of samples to process.
- FSM_zapisz_probki  in  1  latch ile_probek, clear address.
- FSM_reset_licznik  in  1  synchronous clear of the address.
- FSM_nowa_probka  in  1  advance to the next sample.
- A_probki_FIR  out  ADDR_WIDTH  current sample address.
- licznik_full  out  1  current address is the last sample.

Behaviour:
- Reset (rst=1, asynchronous): Acc_out=0, FIR_probka_wynik=0, A_probki_FIR=0, stored count=0.
- Adder (combinational, zero latency):
  - suma_wynik = Acc_out + {{(WIDTH-16){mnozenie_wynik[15]}}, mnozenie_wynik}.
  - Result is two's complement, modulo 2^WIDTH (wraps on overflow).
- Accumulator, per clock, in priority order:
  - FSM_reset_Acc: Acc_out <= 0.
  - else FSM_Acc_en: Acc_out <= suma_wynik.
  - else hold.
- Capture:
  - FSM_Acc_zapis: FIR_probka_wynik <= Acc_out (pre-edge value).
  - Independent of the accumulator priority: capture together with FSM_reset_Acc stores the old sum; capture together with FSM_Acc_en stores the value before the add.
  - Otherwise FIR_probka_wynik holds.
- Counter: stored count N is a CNT_WIDTH register. Per clock, in priority order:
  - FSM_zapisz_probki: N <= ile_probek, address <= 0.
  - else FSM_reset_licznik: address <= 0.
  - else FSM_nowa_probka and !licznik_full: address <= address+1.
  - else hold.
- licznik_full = (A_probki_FIR == N-1) when N >= 1; licznik_full = 1 when N == 0. Combinational from the registers.
- At full, FSM_nowa_probka is ignored: the address saturates and never wraps.
- N larger than 2^ADDR_WIDTH: the address saturates at all-ones and full never asserts. Software must not program this.
- All FSM controls are single-cycle, level-sampled strobes. There is no handshake.

Optional Feature:
- Macro FIR_ACC_SAT_EN.
- Defined: the adder saturates on signed overflow:
  - positive overflow gives 0x0FFFFF;
  - negative overflow gives 0x100000 (for WIDTH=21, i.e. max/min signed).
  - Overflow is detected when both operands have the same sign and the result sign differs.
- Undefined: the adder wraps modulo 2^WIDTH.

Decomposition:
- Package fir_pkg holds:
  - localparams FIR_ACC_W=21, FIR_ADDR_W=13, FIR_CNT_W=14;
  - typedefs acc_t (logic signed [FIR_ACC_W-1:0]) and addr_t.
- One sub-module is natural: fir_sum_add (combinational sign-extend + add, plus the optional saturation).
- Accumulator and counter stay inline.

Test Plan:
- Reset mid-run: Acc_out=0x3000, address=2, assert rst for 3 ns without a clock edge -> all outputs 0 immediately.
- Accumulate: term 0x1000 (0.5*0.25), FSM_Acc_en for 3 cycles -> Acc_out 0x1000, 0x2000, 0x3000. Then FSM_Acc_zapis -> FIR_probka_wynik=0x3000.
- Negative term: Acc_out=0, term 0xC000 -> suma_wynik=0x1FC000. Accumulate, then add 0x4000 -> Acc_out=0x000000.
- Simultaneous strobes:
  - FSM_reset_Acc+FSM_Acc_zapis with Acc_out=0x3000 -> result 0x3000, Acc_out 0.
  - FSM_reset_Acc+FSM_Acc_en -> Acc_out 0.
- Counter: ile_probek=3, zapisz strobe -> address 0, full=0. Two nowa_probka -> address 2, full=1. Third nowa_probka -> stays 2. reset_licznik -> 0. Programming ile_probek=0 -> full=1 immediately.
- FIR_ACC_SAT_EN: Acc_out=0x0FF000, term 0x7FFF -> suma_wynik=0x0FFFFF with the macro, 0x106FFF without it.
